// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: shared state encoding, decoded-instruction flags and constants for the core sequencer.
package core_sequencer_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERROR
    } seq_state_t;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic writes_to_reg;
    } instr_t;

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: per-stage enable/completed handshakes plus decode and branch results.
interface core_sequencer_if;
    import core_sequencer_pkg::*;

    logic        fetch_enabled;
    logic        fetch_completed;
    logic        decode_enabled;
    logic        decode_completed;
    logic        exec_enabled;
    logic        exec_completed;
    logic        mem_enabled;
    logic        mem_completed;
    logic        wb_enabled;
    logic        wb_completed;
    logic        br_taken;
    logic [31:0] br_target;
    instr_t      instr;

    modport master (
        output fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
        input  fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed,
        input  br_taken, br_target, instr
    );

    modport slave (
        input  fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled,
        output fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed,
        output br_taken, br_target, instr
    );

endinterface

// File: rtl/core_perf_counter.sv
// core_perf_counter: 64-bit busy-cycle and retired-instruction counters, both wrapping.
module core_perf_counter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        busy,
    input  logic        retire,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret
);

    logic [63:0] cycle_q, cycle_d, instret_q, instret_d;

    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;

    // Advance each counter by its one-bit event.
    always_comb begin
        cycle_d   = cycle_q + 64'(busy);
        instret_d = instret_q + 64'(retire);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: sequences fetch/decode/exec/mem/write stages, owns the PC, watchdogs each stage.
// Defining CORE_SEQ_PERF_CNT_EN adds cycle_cnt/instret performance counter outputs.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             halt_req,
    core_sequencer_if.master bus,
    output logic [31:0]      pc,
    output logic             busy,
`ifdef CORE_SEQ_PERF_CNT_EN
    output logic             error,
    output logic [63:0]      cycle_cnt,
    output logic [63:0]      instret
`else
    output logic             error
`endif
);

    seq_state_t  state_q, state_d;
    logic        first_q, first_d;
    logic        wr_q, wr_d;
    logic [31:0] pc_q, pc_d, next_pc_q, next_pc_d, wdog_q, wdog_d, exec_pc;
    logic        done, retire, mem_op;

    assign busy  = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign error = state_q == S_ERROR;
    assign pc    = pc_q;

    assign bus.fetch_enabled  = first_q && state_q == S_FETCH;
    assign bus.decode_enabled = first_q && state_q == S_DECODE;
    assign bus.exec_enabled   = first_q && state_q == S_EXEC;
    assign bus.mem_enabled    = first_q && state_q == S_MEM;
    assign bus.wb_enabled     = first_q && state_q == S_WB;

    // Stage sequencing, PC update and watchdog; completions are ignored in a stage's enable cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        wr_d      = wr_q;
        wdog_d    = wdog_q;
        retire    = 1'b0;
        mem_op    = bus.instr.is_load || bus.instr.is_store;
        exec_pc   = bus.br_taken ? bus.br_target : pc_q + 32'(INSTR_BYTES);
        done      = !first_q && (state_q == S_FETCH  ? bus.fetch_completed  :
                                 state_q == S_DECODE ? bus.decode_completed :
                                 state_q == S_EXEC   ? bus.exec_completed   :
                                 state_q == S_MEM    ? bus.mem_completed    :
                                 state_q == S_WB     ? bus.wb_completed     : 1'b0);
        case (state_q)
            S_IDLE:   state_d = (start && !halt_req) ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = done ? S_DECODE : S_FETCH;
            S_DECODE: state_d = done ? S_EXEC : S_DECODE;
            S_EXEC: if (done) begin
                next_pc_d = exec_pc;
                wr_d      = bus.instr.writes_to_reg;
                state_d   = mem_op ? S_MEM : bus.instr.writes_to_reg ? S_WB : S_EXEC;
                retire    = !mem_op && !bus.instr.writes_to_reg;
            end
            S_MEM: if (done) begin
                state_d = wr_q ? S_WB : S_MEM;
                retire  = !wr_q;
            end
            S_WB:     retire = done;
            default:  ;
        endcase
        if (retire) begin
            pc_d    = state_q == S_EXEC ? exec_pc : next_pc_q;
            state_d = halt_req ? S_IDLE : S_FETCH;
        end
        if (busy) begin
            wdog_d = first_q ? 32'd0 : wdog_q + 32'd1;
            if (WDOG_CYCLES != 0 && !first_q && !done && wdog_q == 32'(WDOG_CYCLES - 1))
                state_d = S_ERROR;
        end
        first_d = state_d != state_q;
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            first_q   <= 1'b0;
            wr_q      <= 1'b0;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            wr_q      <= wr_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            wdog_q    <= wdog_d;
        end
    end

`ifdef CORE_SEQ_PERF_CNT_EN
    core_perf_counter u_perf (
        .clk       (clk),
        .rstn      (rstn),
        .busy      (busy),
        .retire    (retire),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );
`endif

endmodule
